// File: rtl/fetch_flow_ctrl_if.sv
// Signal bundle between the fetch-stage sequencing controller and the
// surrounding pipeline (fetch, decode and execute stages).
interface fetch_flow_ctrl_if;
  logic [7:0]  pred_pc;
  logic        ex_branch_valid;
  logic [7:0]  ex_branch_pc;
  logic        ex_branch_taken;
  logic [7:0]  ex_branch_target;
  logic        ex_pred_taken;
  logic [7:0]  ex_pred_target;
  logic        hazard_stall;
  logic        halt_req;
  logic        resume;
  logic        stall;
  logic        flush;
  logic        PC_sel;
  logic        predict_taken;
  logic [7:0]  branch_target;
  logic        kill;
  logic        halt;
  logic [15:0] mispredict_cnt;

  // Pipeline side: drives requests and branch resolutions, observes controls.
  modport master (
    output pred_pc, ex_branch_valid, ex_branch_pc, ex_branch_taken,
           ex_branch_target, ex_pred_taken, ex_pred_target,
           hazard_stall, halt_req, resume,
    input  stall, flush, PC_sel, predict_taken, branch_target,
           kill, halt, mispredict_cnt
  );

  // Controller side.
  modport slave (
    input  pred_pc, ex_branch_valid, ex_branch_pc, ex_branch_taken,
           ex_branch_target, ex_pred_taken, ex_pred_target,
           hazard_stall, halt_req, resume,
    output stall, flush, PC_sel, predict_taken, branch_target,
           kill, halt, mispredict_cnt
  );
endinterface

// File: rtl/fetch_flow_ctrl.sv
// Fetch-stage sequencing controller: direct-mapped BTB with 2-bit counters,
// misprediction redirect, hazard stall and halt arbitration for an 8-bit PC.
module fetch_flow_ctrl #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic            clk,
  input  logic            reset,
  fetch_flow_ctrl_if.slave bus
);

  localparam int TAG_W   = 8 - IDX_W;
  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic [1:0] {RUN, REDIRECT, HALT} state_t;

  state_t           state;
  logic             btb_vld [ENTRIES];
  logic [1:0]       btb_cnt [ENTRIES];
  logic [TAG_W-1:0] btb_tag [ENTRIES];
  logic [7:0]       btb_tgt [ENTRIES];
  logic             redir_taken_p1;
  logic [7:0]       redir_tgt_p1;
  logic [15:0]      mp_cnt;

  function automatic logic [1:0] sat_cnt_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_cnt_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [15:0] sat_mp_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // BTB lookup for the PC fetch is reading now (pre-update contents)
  logic [IDX_W-1:0] lk_idx;
  logic             lk_hit;
  assign lk_idx = bus.pred_pc[IDX_W-1:0];
  assign lk_hit = btb_vld[lk_idx] && (btb_tag[lk_idx] == bus.pred_pc[7:IDX_W]);

  // Branch resolution from execute; only meaningful while running
  logic [IDX_W-1:0] ex_idx;
  logic             ex_hit;
  logic             upd_en;
  logic             mp;
  logic [7:0]       fix_tgt;
  assign ex_idx  = bus.ex_branch_pc[IDX_W-1:0];
  assign ex_hit  = btb_vld[ex_idx] && (btb_tag[ex_idx] == bus.ex_branch_pc[7:IDX_W]);
  assign upd_en  = (state == RUN) && bus.ex_branch_valid;
  assign mp      = upd_en &&
                   ((bus.ex_branch_taken != bus.ex_pred_taken) ||
                    (bus.ex_branch_taken && (bus.ex_pred_target != bus.ex_branch_target)));
  assign fix_tgt = bus.ex_branch_taken ? bus.ex_branch_target : bus.ex_branch_pc + 8'd1;

  // Control state: FSM, redirect latch, BTB valid/counters, mispredict count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      redir_taken_p1 <= 1'b0;
      redir_tgt_p1   <= 8'h00;
      mp_cnt         <= 16'h0000;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_vld[i] <= 1'b0;
        btb_cnt[i] <= 2'b01;
      end
    end else begin
      case (state)
        RUN: begin
          if (upd_en) begin
            if (ex_hit) begin
              btb_cnt[ex_idx] <= bus.ex_branch_taken ? sat_cnt_inc(btb_cnt[ex_idx])
                                                     : sat_cnt_dec(btb_cnt[ex_idx]);
            end else if (bus.ex_branch_taken) begin
              btb_vld[ex_idx] <= 1'b1;
              btb_cnt[ex_idx] <= CNT_INIT;
            end
          end
          // A mispredict wins over halt_req: that HALT sits on the wrong path.
          if (mp) begin
            redir_taken_p1 <= bus.ex_branch_taken;
            redir_tgt_p1   <= fix_tgt;
            mp_cnt         <= sat_mp_inc(mp_cnt);
            state          <= REDIRECT;
          end else if (bus.halt_req) begin
            state <= HALT;
          end
        end
        REDIRECT: state <= RUN;
        HALT: begin
          if (bus.resume) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // BTB tag/target payload; qualified by the valid bits, so left unreset
  always_ff @(posedge clk) begin
    if (upd_en && bus.ex_branch_taken) begin
      btb_tag[ex_idx] <= bus.ex_branch_pc[7:IDX_W];
      btb_tgt[ex_idx] <= bus.ex_branch_target;
    end
  end

  // Fetch-side controls decoded from state; forced low while reset is held
  always_comb begin
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.PC_sel        = 1'b0;
    bus.predict_taken = 1'b0;
    bus.branch_target = 8'h00;
    bus.kill          = 1'b0;
    bus.halt          = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          bus.stall         = bus.hazard_stall;
          bus.predict_taken = lk_hit && btb_cnt[lk_idx][1];
          bus.branch_target = lk_hit ? btb_tgt[lk_idx] : 8'h00;
        end
        REDIRECT: begin
          bus.PC_sel        = redir_taken_p1;
          bus.flush         = !redir_taken_p1;
          bus.branch_target = redir_tgt_p1;
          bus.kill          = 1'b1;
        end
        HALT: begin
          bus.halt  = 1'b1;
          bus.stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mispredict_cnt = mp_cnt;

endmodule
